pkt_buffer: RTL and testbench

Single-packet store-and-forward buffer between the NetFPGA input datapath and the on-chip processor pipeline. It captures one packet from the 64-bit `in_*` bus into a dual-access word memory, then hands the memory to the processor for in-place reads and writes. On the processor's done pulse it streams the stored packet out on the `out_*` bus and rearms for the next packet. Its `mode` output uses the team's DRAM mode encoding, which the top-level packet FSM consumes.

---
 rtl/pkt_buffer_pkg.sv | 16 +
 rtl/pkt_buffer_mem.sv | 57 +++++
 rtl/pkt_buffer.sv | 215 +++++++++++++++++++++
 tb/tb_pkt_buffer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_buffer_pkg.sv
// Shared definitions for the single-packet store-and-forward buffer.
// The mode encoding is also consumed by the top-level packet FSM.
package pkt_buffer_pkg;

    localparam logic [1:0] MODE_RECV = 2'b00;
    localparam logic [1:0] MODE_PROC = 2'b01;
    localparam logic [1:0] MODE_SEND = 2'b10;

    // State values equal the mode encoding, so mode is the state register itself.
    typedef enum logic [1:0] {
        ST_RECV = MODE_RECV,
        ST_PROC = MODE_PROC,
        ST_SEND = MODE_SEND
    } state_e;

endpackage

// File: rtl/pkt_buffer_mem.sv
// Simple dual-port synchronous RAM holding {ctrl, data} words.
// Port A writes (ctrl field has its own enable), port B reads with a registered output.
module pkt_buffer_mem #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_we,
    input  logic                  a_ctrl_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [CTRL_WIDTH-1:0] a_ctrl,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_data,
    output logic [CTRL_WIDTH-1:0] b_ctrl
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [CTRL_WIDTH-1:0] ctrl_mem [DEPTH];

    logic [DATA_WIDTH-1:0] b_data_d, b_data_q;
    logic [CTRL_WIDTH-1:0] b_ctrl_d, b_ctrl_q;

    always_ff @(posedge clk) begin
        if (a_we) begin
            data_mem[a_addr] <= a_data;
            if (a_ctrl_we) begin
                ctrl_mem[a_addr] <= a_ctrl;
            end
        end
    end

    // Read-before-write on a same-cycle collision; a write followed by a
    // read of the same address in the next cycle sees the new data.
    always_comb begin
        b_data_d = data_mem[b_addr];
        b_ctrl_d = ctrl_mem[b_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_data_q <= '0;
            b_ctrl_q <= '0;
        end else begin
            b_data_q <= b_data_d;
            b_ctrl_q <= b_ctrl_d;
        end
    end

    assign b_data = b_data_q;
    assign b_ctrl = b_ctrl_q;

endmodule

// File: rtl/pkt_buffer.sv
// Single-packet store-and-forward buffer: RECV -> PROC -> SEND -> RECV.
// Optional statistics counters are enabled with the PKT_BUFFER_STATS_EN macro.
module pkt_buffer
    import pkt_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic [ADDR_WIDTH-1:0] proc_addr,
    input  logic [DATA_WIDTH-1:0] proc_wdata,
    input  logic                  proc_we,
    output logic [DATA_WIDTH-1:0] proc_rdata,
    input  logic                  proc_done,
    output logic [1:0]            mode,
    output logic [ADDR_WIDTH:0]   pkt_len,
    output logic                  pkt_trunc
`ifdef PKT_BUFFER_STATS_EN
    ,
    output logic [31:0]           stat_rx_pkts,
    output logic [31:0]           stat_tx_pkts,
    output logic [31:0]           stat_trunc_pkts
`endif
);

    // Handshakes: an input word is taken on a cycle with in_wr && in_rdy.
    // out_wr is a one-cycle push with no stall; out_rdy only gates issuing the
    // next memory read, so one already-issued word may follow a fall of out_rdy.

    state_e                state_d, state_q;
    logic [ADDR_WIDTH:0]   wr_ptr_d, wr_ptr_q;
    logic [ADDR_WIDTH:0]   rd_ptr_d, rd_ptr_q;
    logic [ADDR_WIDTH:0]   pkt_len_d, pkt_len_q;
    logic                  trunc_d, trunc_q;
    logic                  prev_zero_d, prev_zero_q;
    logic                  out_wr_d, out_wr_q;

    logic                  accept;
    logic                  room;
    logic                  eop;
    logic                  issue;
    logic                  last_out;

    logic                  mem_a_we;
    logic                  mem_a_ctrl_we;
    logic [ADDR_WIDTH-1:0] mem_a_addr;
    logic [DATA_WIDTH-1:0] mem_a_data;
    logic [ADDR_WIDTH-1:0] mem_b_addr;
    logic [DATA_WIDTH-1:0] mem_b_data;
    logic [CTRL_WIDTH-1:0] mem_b_ctrl;

    always_comb begin
        accept   = (state_q == ST_RECV) && in_wr;
        // wr_ptr top bit set means the write pointer has reached the depth.
        room     = !wr_ptr_q[ADDR_WIDTH];
        eop      = accept && (in_ctrl != '0) && prev_zero_q;
        issue    = (state_q == ST_SEND) && out_rdy && (rd_ptr_q < pkt_len_q);
        last_out = (state_q == ST_SEND) && out_wr_q && (rd_ptr_q == pkt_len_q);
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pkt_len_d   = pkt_len_q;
        trunc_d     = trunc_q;
        prev_zero_d = prev_zero_q;
        out_wr_d    = issue;
        case (state_q)
            ST_RECV: begin
                if (accept) begin
                    prev_zero_d = (in_ctrl == '0);
                    if (room) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end else begin
                        trunc_d = 1'b1;
                    end
                    if (eop) begin
                        // A dropped EOP word leaves wr_ptr at depth, which is the length.
                        pkt_len_d   = room ? (wr_ptr_q + 1'b1) : wr_ptr_q;
                        prev_zero_d = 1'b0;
                        state_d     = ST_PROC;
                    end
                end
            end
            ST_PROC: begin
                if (proc_done) begin
                    rd_ptr_d = '0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (issue) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                if (last_out) begin
                    state_d     = ST_RECV;
                    wr_ptr_d    = '0;
                    pkt_len_d   = '0;
                    trunc_d     = 1'b0;
                    prev_zero_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_RECV;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RECV;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_len_q   <= '0;
            trunc_q     <= 1'b0;
            prev_zero_q <= 1'b0;
            out_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_len_q   <= pkt_len_d;
            trunc_q     <= trunc_d;
            prev_zero_q <= prev_zero_d;
            out_wr_q    <= out_wr_d;
        end
    end

    // Port A belongs to the receive writer in RECV and to the processor
    // otherwise; processor writes leave the stored ctrl byte untouched.
    always_comb begin
        mem_a_we      = (accept && room) || ((state_q == ST_PROC) && proc_we);
        mem_a_ctrl_we = (state_q == ST_RECV);
        mem_a_addr    = (state_q == ST_RECV) ? wr_ptr_q[ADDR_WIDTH-1:0] : proc_addr;
        mem_a_data    = (state_q == ST_RECV) ? in_data : proc_wdata;
        mem_b_addr    = (state_q == ST_SEND) ? rd_ptr_q[ADDR_WIDTH-1:0] : proc_addr;
    end

    pkt_buffer_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_we      (mem_a_we),
        .a_ctrl_we (mem_a_ctrl_we),
        .a_addr    (mem_a_addr),
        .a_data    (mem_a_data),
        .a_ctrl    (in_ctrl),
        .b_addr    (mem_b_addr),
        .b_data    (mem_b_data),
        .b_ctrl    (mem_b_ctrl)
    );

    always_comb begin
        mode       = state_q;
        in_rdy     = (state_q == ST_RECV);
        out_wr     = out_wr_q;
        out_data   = out_wr_q ? mem_b_data : '0;
        out_ctrl   = out_wr_q ? mem_b_ctrl : '0;
        proc_rdata = mem_b_data;
        pkt_len    = pkt_len_q;
        pkt_trunc  = trunc_q;
    end

`ifdef PKT_BUFFER_STATS_EN
    logic [31:0] rx_pkts_d, rx_pkts_q;
    logic [31:0] tx_pkts_d, tx_pkts_q;
    logic [31:0] trunc_pkts_d, trunc_pkts_q;

    always_comb begin
        rx_pkts_d    = rx_pkts_q;
        tx_pkts_d    = tx_pkts_q;
        trunc_pkts_d = trunc_pkts_q;
        if (eop) begin
            rx_pkts_d = rx_pkts_q + 32'd1;
            if (trunc_d) begin
                trunc_pkts_d = trunc_pkts_q + 32'd1;
            end
        end
        if (last_out) begin
            tx_pkts_d = tx_pkts_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_pkts_q    <= '0;
            tx_pkts_q    <= '0;
            trunc_pkts_q <= '0;
        end else begin
            rx_pkts_q    <= rx_pkts_d;
            tx_pkts_q    <= tx_pkts_d;
            trunc_pkts_q <= trunc_pkts_d;
        end
    end

    assign stat_rx_pkts    = rx_pkts_q;
    assign stat_tx_pkts    = tx_pkts_q;
    assign stat_trunc_pkts = trunc_pkts_q;
`endif

endmodule

// File: tb/tb_pkt_buffer.sv
// Bench for pkt_buffer: random packets through RECV/PROC/SEND against a
// packet-level reference model, with a queue-based output scoreboard.
`timescale 1ns/1ps
module tb_pkt_buffer;
    import pkt_buffer_pkg::*;

    localparam int DW    = 64;
    localparam int CW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int WW    = DW + CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          in_wr = 1'b0;
    logic          in_rdy;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          out_wr;
    logic          out_rdy = 1'b0;
    logic [AW-1:0] proc_addr = '0;
    logic [DW-1:0] proc_wdata = '0;
    logic          proc_we = 1'b0;
    logic [DW-1:0] proc_rdata;
    logic          proc_done = 1'b0;
    logic [1:0]    mode;
    logic [AW:0]   pkt_len;
    logic          pkt_trunc;
`ifdef PKT_BUFFER_STATS_EN
    logic [31:0]   stat_rx_pkts;
    logic [31:0]   stat_tx_pkts;
    logic [31:0]   stat_trunc_pkts;
`endif

    pkt_buffer #(
        .DATA_WIDTH (DW),
        .CTRL_WIDTH (CW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .in_wr      (in_wr),
        .in_rdy     (in_rdy),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .out_wr     (out_wr),
        .out_rdy    (out_rdy),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_we    (proc_we),
        .proc_rdata (proc_rdata),
        .proc_done  (proc_done),
        .mode       (mode),
        .pkt_len    (pkt_len),
        .pkt_trunc  (pkt_trunc)
`ifdef PKT_BUFFER_STATS_EN
        ,
        .stat_rx_pkts    (stat_rx_pkts),
        .stat_tx_pkts    (stat_tx_pkts),
        .stat_trunc_pkts (stat_trunc_pkts)
`endif
    );

    // Clock and reset helpers.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int checks = 0;
    int errors = 0;

    logic [WW-1:0] exp_q[$];
    logic [CW-1:0] mdl_ctrl[DEPTH];
    logic [DW-1:0] mdl_data[DEPTH];
    bit            mdl_valid[DEPTH];
    logic [CW-1:0] pkt_ctrl[16];
    logic [DW-1:0] pkt_data[16];
    int            exp_len;
    bit            exp_trunc;
    int            st_rx = 0;
    int            st_tx = 0;
    int            st_trunc = 0;
    int            words_seen = 0;
    bit            expect_recv_next = 1'b0;
    logic          prev_rdy = 1'b0;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_wr     = 1'b0;
        proc_we   = 1'b0;
        proc_done = 1'b0;
        out_rdy   = 1'b0;
        exp_q.delete();
        expect_recv_next = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl_valid[i] = 1'b0;
        st_rx = 0; st_tx = 0; st_trunc = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Monitor / scoreboard: compares every emitted word against the queue head.
    initial begin
        logic [WW-1:0] w;
        forever begin
            @(negedge clk);
            if (expect_recv_next) begin
                expect_recv_next = 1'b0;
                check("mode_after_last_out", {mode, in_rdy}, {MODE_RECV, 1'b1});
            end
            if (out_wr) begin
                check("out_rdy_before_out_wr", prev_rdy, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_wr: actual=%0h expected=no word", {out_ctrl, out_data});
                end else begin
                    w = exp_q.pop_front();
                    check("out_word", {out_ctrl, out_data}, w);
                    words_seen++;
                    if (exp_q.size() == 0) begin
                        expect_recv_next = 1'b1;
                        st_tx++;
                    end
                end
            end
            prev_rdy = out_rdy;
        end
    end

    // Driver: feed one packet from pkt_ctrl/pkt_data; the model derives the
    // stored image from the end-of-packet and overflow rules.
    task automatic recv_pkt(input int n);
        int eop;
        eop = -1;
        for (int i = 1; i < n; i++) begin
            if (eop < 0 && pkt_ctrl[i] != 0 && pkt_ctrl[i-1] == 0) eop = i;
        end
        exp_len   = (eop + 1 > DEPTH) ? DEPTH : eop + 1;
        exp_trunc = (eop + 1 > DEPTH);
        for (int i = 0; i < exp_len; i++) begin
            mdl_ctrl[i]  = pkt_ctrl[i];
            mdl_data[i]  = pkt_data[i];
            mdl_valid[i] = 1'b1;
        end
        for (int i = 0; i <= eop; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                in_wr     = 1'b0;
                proc_done = ($urandom_range(0, 3) == 0);
                tick();
            end
            proc_done = 1'b0;
            in_wr     = 1'b1;
            in_ctrl   = pkt_ctrl[i];
            in_data   = pkt_data[i];
            tick();
        end
        in_wr = 1'b0;
        check("mode_proc", mode, MODE_PROC);
        check("in_rdy_proc", in_rdy, 0);
        check("pkt_len", pkt_len, exp_len);
        check("pkt_trunc", pkt_trunc, exp_trunc);
        st_rx++;
        if (exp_trunc) st_trunc++;
        // A word offered while in_rdy is low must be dropped.
        in_wr   = 1'b1;
        in_ctrl = 8'h5A;
        in_data = {$urandom, $urandom};
        tick();
        in_wr = 1'b0;
    endtask

    task automatic proc_write(input int a, input logic [DW-1:0] d);
        proc_addr  = AW'(a);
        proc_wdata = d;
        proc_we    = 1'b1;
        tick();
        proc_we      = 1'b0;
        mdl_data[a]  = d;
        mdl_valid[a] = 1'b1;
    endtask

    task automatic proc_read(input int a);
        proc_addr = AW'(a);
        tick();
        if (mdl_valid[a]) check("proc_rdata", proc_rdata, mdl_data[a]);
    endtask

    task automatic proc_random_ops();
        int k;
        k = $urandom_range(0, 4);
        for (int i = 0; i < k; i++) begin
            if ($urandom_range(0, 1) == 1) proc_write($urandom_range(0, DEPTH-1), {$urandom, $urandom});
            else proc_read($urandom_range(0, DEPTH-1));
        end
    endtask

    // Release the packet and drain it; rdy_mode 0 = always ready,
    // 1 = ready pattern 1,0,0 repeating, 2 = random.
    task automatic release_and_drain(input int rdy_mode);
        int cyc;
        for (int i = 0; i < exp_len; i++) exp_q.push_back({mdl_ctrl[i], mdl_data[i]});
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        check("mode_send", mode, MODE_SEND);
        check("no_early_out_wr", out_wr, 0);
        cyc = 0;
        while ((exp_q.size() != 0 || mode != MODE_RECV) && cyc < 200) begin
            case (rdy_mode)
                0:       out_rdy = 1'b1;
                1:       out_rdy = (cyc % 3 == 0);
                default: out_rdy = ($urandom_range(0, 1) == 1);
            endcase
            proc_we    = ($urandom_range(0, 3) == 0);
            proc_addr  = AW'($urandom_range(0, DEPTH-1));
            proc_wdata = {$urandom, $urandom};
            proc_done  = ($urandom_range(0, 7) == 0);
            in_wr      = ($urandom_range(0, 3) == 0);
            in_ctrl    = 8'h00;
            tick();
            cyc++;
        end
        proc_we   = 1'b0;
        proc_done = 1'b0;
        in_wr     = 1'b0;
        out_rdy   = 1'b0;
        if (cyc >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: actual=%0d words left expected=0", exp_q.size());
            do_reset();
        end else begin
            check("pkt_len_cleared", pkt_len, 0);
            check("pkt_trunc_cleared", pkt_trunc, 0);
        end
    endtask

    task automatic gen_random_pkt(output int n);
        n = $urandom_range(2, 7);
        pkt_ctrl[0] = (n > 2 && $urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
        for (int i = 1; i < n - 1; i++) pkt_ctrl[i] = 8'h00;
        pkt_ctrl[n-1] = CW'($urandom_range(1, 255));
        for (int i = 0; i < n; i++) pkt_data[i] = {$urandom, $urandom};
    endtask

`ifdef PKT_BUFFER_STATS_EN
    task automatic check_stats();
        check("stat_rx_pkts", stat_rx_pkts, st_rx);
        check("stat_tx_pkts", stat_tx_pkts, st_tx);
        check("stat_trunc_pkts", stat_trunc_pkts, st_trunc);
    endtask
`endif

    initial begin
        int n;
        int target;
        int waited;
        do_reset();
        rst_n = 1'b0;
        tick();
        check("rst_mode", mode, MODE_RECV);
        check("rst_in_rdy", in_rdy, 1);
        check("rst_out_wr", out_wr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_proc_rdata", proc_rdata, 0);
        check("rst_pkt_len", pkt_len, 0);
        check("rst_pkt_trunc", pkt_trunc, 0);
        rst_n = 1'b1;
        tick();

        // Directed: 4-word packet that exactly fills the buffer, in-place edit.
        pkt_ctrl[0] = 8'hFF; pkt_ctrl[1] = 8'h00; pkt_ctrl[2] = 8'h00; pkt_ctrl[3] = 8'h01;
        for (int i = 0; i < 4; i++) pkt_data[i] = DW'(i + 1);
        recv_pkt(4);
        proc_write(2, 64'hAA);
        proc_read(2);
        check("proc_rdata_aa", proc_rdata, 64'hAA);
        release_and_drain(0);

        // Directed: 6-word packet overflows a 4-word buffer.
        pkt_ctrl[0] = 8'hFF;
        for (int i = 1; i < 5; i++) pkt_ctrl[i] = 8'h00;
        pkt_ctrl[5] = 8'h01;
        for (int i = 0; i < 6; i++) pkt_data[i] = DW'(16 + i);
        recv_pkt(6);
        proc_read(3);
        release_and_drain(1);

        for (int p = 0; p < 40; p++) begin
            gen_random_pkt(n);
            recv_pkt(n);
            proc_random_ops();
            release_and_drain($urandom_range(0, 2));
        end
`ifdef PKT_BUFFER_STATS_EN
        check_stats();
`endif

        // Reset in the middle of SEND, after the second word.
        pkt_ctrl[0] = 8'hFF; pkt_ctrl[1] = 8'h00; pkt_ctrl[2] = 8'h00; pkt_ctrl[3] = 8'h02;
        for (int i = 0; i < 4; i++) pkt_data[i] = {$urandom, $urandom};
        recv_pkt(4);
        for (int i = 0; i < exp_len; i++) exp_q.push_back({mdl_ctrl[i], mdl_data[i]});
        target = words_seen + 2;
        out_rdy = 1'b1;
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        waited = 0;
        while (words_seen < target && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited >= 50) begin
            checks++;
            errors++;
            $display("FAIL mid_send_wait: actual=%0d words expected=%0d", words_seen, target);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_mode", mode, MODE_RECV);
        check("midrst_out_wr", out_wr, 0);
        check("midrst_in_rdy", in_rdy, 1);
        check("midrst_pkt_len", pkt_len, 0);
        do_reset();
`ifdef PKT_BUFFER_STATS_EN
        check_stats();
`endif

        gen_random_pkt(n);
        recv_pkt(n);
        proc_random_ops();
        release_and_drain(2);
`ifdef PKT_BUFFER_STATS_EN
        check_stats();
`endif
        tick();
        tick();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_words: actual=%0d expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
